// File: rtl/proc_core_mc.sv
// Multi-cycle accumulator-less register core: FETCH/DECODE/EXEC(/MEM) sequencing, 3 cycles per instruction
// (LOAD 4, IN stalls in EXEC until in_valid); single-port ROM and RAM with 1-cycle synchronous reads.
module proc_core_mc #(
  parameter int DW   = 8,
  parameter int NREG = 16,
  parameter int PW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic [7:0]    dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_we,
  input  logic [DW-1:0] dmem_rdata,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          halted,
  output logic          flag_z,
  output logic          flag_c
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LI    = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_IN    = 4'd10;
  localparam logic [3:0] OP_OUT   = 4'd11;
  localparam logic [3:0] OP_JZ    = 4'd12;
  localparam logic [3:0] OP_JMP   = 4'd13;
  localparam logic [3:0] OP_JC    = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic [3:0]    opcode, rd, rs;
  logic [7:0]    imm;
  logic [DW-1:0] ra, rb;
  logic [DW:0]   sum, diff;
  logic [DW-1:0] alu_res;
  logic          alu_c, alu_op;
  logic          wr_en;
  logic [DW-1:0] wr_val;

  assign opcode = ir_q[15:12];
  assign rd     = ir_q[11:8];
  assign imm    = ir_q[7:0];
  assign rs     = ir_q[3:0];

  // Register indices beyond NREG read as zero.
  always_comb begin
    ra = '0;
    rb = '0;
    if (int'(rd) < NREG) ra = regs_q[rd];
    if (int'(rs) < NREG) rb = regs_q[rs];
  end

  always_comb begin
    sum     = {1'b0, ra} + {1'b0, rb};
    diff    = {1'b0, ra} - {1'b0, rb};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_op  = 1'b1;
    case (opcode)
      OP_ADD: begin alu_res = sum[DW-1:0];  alu_c = sum[DW];  end
      OP_SUB: begin alu_res = diff[DW-1:0]; alu_c = diff[DW]; end
      OP_AND: alu_res = ra & rb;
      OP_OR:  alu_res = ra | rb;
      OP_XOR: alu_res = ra ^ rb;
      OP_NOT: alu_res = ~ra;
      default: alu_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_val      = '0;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = imem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PW'(1);
        if (alu_op) begin
          wr_en    = 1'b1;
          wr_val   = alu_res;
          flag_z_d = (alu_res == '0);
          flag_c_d = alu_c;
        end
        case (opcode)
          OP_LI: begin
            wr_en  = 1'b1;
            wr_val = DW'(imm);
          end
          OP_LOAD: begin
            state_d = ST_MEM;
            pc_d    = pc_q;
          end
          OP_IN: begin
            if (in_valid) begin
              wr_en    = 1'b1;
              wr_val   = in_data;
              flag_z_d = (in_data == '0);
            end else begin
              state_d = ST_EXEC;
              pc_d    = pc_q;
            end
          end
          OP_OUT: begin
            out_data_d  = ra;
            out_valid_d = 1'b1;
          end
          OP_JZ:  if (flag_z_q) pc_d = PW'(imm);
          OP_JC:  if (flag_c_q) pc_d = PW'(imm);
          OP_JMP: pc_d = PW'(imm);
          OP_HALT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        wr_en    = 1'b1;
        wr_val   = dmem_rdata;
        flag_z_d = (dmem_rdata == '0);
        pc_d     = pc_q + PW'(1);
        state_d  = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
    if (wr_en && int'(rd) < NREG) regs_d[rd] = wr_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = imm;
  assign dmem_wdata = ra;
  assign dmem_we    = (state_q == ST_EXEC) && (opcode == OP_STORE);
  assign in_ready   = (state_q == ST_EXEC) && (opcode == OP_IN);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign halted     = (state_q == ST_HALT);
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;

endmodule

// File: doc/proc_core_mc.md
PROC_CORE_MC -- requirements
Module: proc_core_mc

Interface
REQ-001 Parameter DW, default 8: data and register width; legal range 4..16.
REQ-002 Parameter NREG, default 16: number of general registers; legal range 2..16.
REQ-003 Parameter PW, default 8: program-counter and instruction-address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  PW  instruction address (the PC); the ROM has 1-cycle synchronous read.
REQ-007 imem_rdata  in  16  instruction word: opcode[15:12], rd[11:8], imm[7:0].
REQ-008 dmem_addr  out  8  data RAM address; equals imm.
REQ-009 dmem_wdata  out  DW  store data; equals R[rd].
REQ-010 dmem_we  out  1  write strobe; 1-cycle synchronous read/write RAM.
REQ-011 dmem_rdata  in  DW  RAM read data, valid one cycle after the address.
REQ-012 in_data / in_valid  in  DW / 1  input port, valid/ready handshake.
REQ-013 in_ready  out  1  core is waiting on an IN instruction.
REQ-014 out_data / out_valid  out  DW / 1  output register; out_valid is a 1-cycle strobe.
REQ-015 halted, flag_z, flag_c  out  1 each  status outputs.

Function
REQ-016 Opcodes: 0 NOP, 1 LI, 2 LOAD, 3 STORE, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 NOT, 10 IN, 11 OUT, 12 JZ, 13 JMP, 14 JC, 15 HALT.
REQ-017 FSM states and sequence: FETCH -> DECODE -> EXEC -> (MEM for LOAD) -> FETCH; the HALT state is terminal.
REQ-018 Instruction-word latching:
- FETCH drives imem_addr=PC.
- DECODE latches imem_rdata into IR.
- EXEC and MEM use IR only.
REQ-019 Latency in cycles: NOP/LI/STORE/ALU/OUT/jumps 3; LOAD 4; IN 3 plus the number of stall cycles.
REQ-020 LI: R[rd] <= imm zero-extended to DW, or truncated to the low DW bits when DW<8; flags unchanged.
REQ-021 ALU ops: R[rd] <= R[rd] op R[imm[3:0]].
- NOT: R[rd] <= ~R[rd].
- Arithmetic is modulo 2^DW.
REQ-022 Flag updates:
- flag_z = (result==0) after ALU ops, LOAD and IN.
- flag_c = carry-out for ADD, borrow for SUB (set when R[rd] < R[src]).
- flag_c cleared by AND/OR/XOR/NOT.
- All other instructions leave both flags unchanged.
REQ-023 STORE: dmem_we=1 for exactly the EXEC cycle, with dmem_addr=imm and dmem_wdata=R[rd]; dmem_we=0 in all other cycles.
REQ-024 LOAD: address is driven in EXEC; R[rd] <= dmem_rdata in MEM.
REQ-025 IN handshake:
- EXEC holds in_ready=1 until in_valid=1.
- In the cycle where in_ready and in_valid are both 1: R[rd] <= in_data, then go to FETCH.
- in_data is ignored while in_valid=0.
REQ-026 OUT: out_data <= R[rd] and out_valid=1 for one cycle after EXEC; out_data holds its value until the next OUT.
REQ-027 Jumps: JMP sets PC <= imm[PW-1:0]; JZ/JC do so only when flag_z/flag_c =1; otherwise PC <= PC+1.
REQ-028 PC increments in EXEC (MEM for LOAD) and wraps from 2^PW-1 to 0.
REQ-029 A register index >= NREG reads 0 and discards the write.
REQ-030 HALT: enters the HALT state, halted=1, no further strobes; the PC stays at the HALT address until reset.
REQ-031 Flag-reading instructions see the flag state of the immediately preceding instruction.

Reset
REQ-032 When rst=0, asynchronously: PC=0, FSM=FETCH, IR=0, all registers=0, flags=0, out_data=0, out_valid=0, dmem_we=0, in_ready=0, halted=0.
REQ-033 Reset asserted mid-instruction aborts it; no partial register or RAM write occurs after the asserting edge.
REQ-034 After rst returns to 1, the first FETCH occurs on the next rising clk edge, at address 0.

Verification
REQ-035 LI r1,200; LI r2,100; ADD r1,r2 -> R1=44, flag_c=1, flag_z=0; each instruction takes 3 cycles.
REQ-036 LI r3,5; SUB r3,r3; JZ 0x20 -> R3=0, flag_z=1, next imem_addr=0x20; repeat with flag_z=0 -> PC advances by 1.
REQ-037 STORE r1,0x10; LOAD r4,0x10 -> one dmem_we pulse at addr 0x10 with data 44; R4=44 after 4 cycles.
REQ-038 IN r5 with in_valid held low for 5 cycles, then in_data=0x3C -> in_ready high for 6 cycles; R5=0x3C; OUT r5 -> out_valid pulses once, out_data=0x3C.
REQ-039 PC at 0xFF executing NOP -> next fetch at 0x00; HALT -> halted=1, PC frozen, no strobes for 20 cycles.
REQ-040 Assert rst during the MEM cycle of a LOAD -> target register stays 0; all outputs take their REQ-032 values immediately.
